// File: rtl/bram_playback_sequencer_if.sv
// rtl/bram_playback_sequencer_if.sv - control, config and link-side signals of the playback sequencer
interface bram_playback_sequencer_if #(
  parameter int N_LINKS   = 4,
  parameter int CNT_WIDTH = 16
);
  logic                 start;
  logic                 abort;
  logic                 fc_orbitSync;
  logic [N_LINKS-1:0]   cfg_link_mask;
  logic [CNT_WIDTH-1:0] cfg_delay;
  logic [3:0]           cfg_period;
  logic [CNT_WIDTH-1:0] cfg_repeat;
  logic [N_LINKS-1:0]   link_sync;
  logic [N_LINKS-1:0]   link_enable;
  logic [1:0]           state;
  logic                 busy;
  logic                 done;
  logic [CNT_WIDTH-1:0] pattern_count;

  modport master (
    output start, abort, fc_orbitSync, cfg_link_mask, cfg_delay, cfg_period, cfg_repeat,
    input  link_sync, link_enable, state, busy, done, pattern_count
  );

  modport slave (
    input  start, abort, fc_orbitSync, cfg_link_mask, cfg_delay, cfg_period, cfg_repeat,
    output link_sync, link_enable, state, busy, done, pattern_count
  );
endinterface

// File: rtl/bram_playback_sequencer.sv
// rtl/bram_playback_sequencer.sv - orbit-synchronous run controller issuing pattern sync pulses to playback links
module bram_playback_sequencer #(
  parameter int N_LINKS   = 4,
  parameter int CNT_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    aresetn,
  bram_playback_sequencer_if.slave bus
);
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_RUN   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] C_ONE = CNT_WIDTH'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_orb_q;
  logic                 w_orb;
  logic [N_LINKS-1:0]   r_mask;
  logic [N_LINKS-1:0]   r_link_sync;
  logic [N_LINKS-1:0]   r_link_enable;
  logic [CNT_WIDTH-1:0] r_delay_cnt;
  logic [CNT_WIDTH-1:0] r_repeat;
  logic [CNT_WIDTH-1:0] r_pattern_count;
  logic [CNT_WIDTH-1:0] w_delay_nxt;
  logic [CNT_WIDTH-1:0] w_count_nxt;
  logic [3:0]           r_period_m1;
  logic [3:0]           r_phase_cnt;
  logic [3:0]           w_phase_nxt;
  logic                 r_busy;
  logic                 r_done;
  logic                 w_pulse;
  logic                 w_latch;

  assign w_orb = bus.fc_orbitSync & ~r_orb_q;

  always_comb begin
    w_state_nxt = r_state;
    w_delay_nxt = r_delay_cnt;
    w_phase_nxt = r_phase_cnt;
    w_count_nxt = r_pattern_count;
    w_pulse     = 1'b0;
    w_latch     = 1'b0;
    if (bus.abort) begin
      w_state_nxt = S_IDLE;
      w_count_nxt = '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          // An orbit coinciding with the accepted start is deliberately not counted.
          if (bus.start) begin
            w_state_nxt = S_ARMED;
            w_latch     = 1'b1;
            w_delay_nxt = bus.cfg_delay;
            w_count_nxt = '0;
          end
        end
        S_ARMED: begin
          if (w_orb) begin
            if (r_delay_cnt != '0) begin
              w_delay_nxt = r_delay_cnt - C_ONE;
            end else begin
              w_state_nxt = S_RUN;
              w_pulse     = 1'b1;
              w_count_nxt = C_ONE;
              w_phase_nxt = r_period_m1;
            end
          end
        end
        S_RUN: begin
          if (w_orb) begin
            if (r_phase_cnt != 4'd0) begin
              w_phase_nxt = r_phase_cnt - 4'd1;
            end else if ((r_repeat != '0) && (r_pattern_count == r_repeat)) begin
              w_state_nxt = S_DONE;
            end else begin
              w_pulse     = 1'b1;
              w_count_nxt = r_pattern_count + C_ONE;
              w_phase_nxt = r_period_m1;
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_orb_q         <= 1'b0;
      r_mask          <= '0;
      r_repeat        <= '0;
      r_period_m1     <= 4'd0;
      r_delay_cnt     <= '0;
      r_phase_cnt     <= 4'd0;
      r_pattern_count <= '0;
      r_link_sync     <= '0;
      r_link_enable   <= '0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
    end else begin
      r_orb_q         <= bus.fc_orbitSync;
      r_delay_cnt     <= w_delay_nxt;
      r_phase_cnt     <= w_phase_nxt;
      r_pattern_count <= w_count_nxt;
      if (w_latch) begin
        r_mask      <= bus.cfg_link_mask;
        r_repeat    <= bus.cfg_repeat;
        r_period_m1 <= (bus.cfg_period == 4'd0) ? 4'd0 : bus.cfg_period - 4'd1;
      end
      // Outputs are registered from the next state so they line up with bus.state.
      r_link_sync   <= w_pulse ? r_mask : '0;
      r_link_enable <= (w_state_nxt == S_RUN) ? r_mask : '0;
      r_busy        <= (w_state_nxt == S_ARMED) || (w_state_nxt == S_RUN);
      r_done        <= (w_state_nxt == S_DONE);
    end
  end

  assign bus.state         = r_state;
  assign bus.link_sync     = r_link_sync;
  assign bus.link_enable   = r_link_enable;
  assign bus.busy          = r_busy;
  assign bus.done          = r_done;
  assign bus.pattern_count = r_pattern_count;
endmodule
